// File: rtl/otter_io_pkg.sv
// Shared address map and seven-segment helpers for the OTTER board wrapper.
`timescale 1ns/1ps
package otter_io_pkg;

  localparam logic [31:0] SWITCHES_AD = 32'h1100_0000;
  localparam logic [31:0] BUTTONS_AD  = 32'h1100_8000;
  localparam logic [31:0] LEDS_AD     = 32'h1108_0000;
  localparam logic [31:0] SSEG_AD     = 32'h110C_0000;

  localparam logic [3:0] AN_OFF     = 4'hF;
  localparam logic [7:0] SEGS_BLANK = 8'hFF;

  // Active-low pattern {dp,g,f,e,d,c,b,a}; dp is always dark.
  function automatic logic [7:0] hex_to_segs(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
      default: s = SEGS_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/OTTER_MCU.sv
// Minimal stand-in for the OTTER core: echoes the last bus read to the LED
// register whenever an interrupt is taken.
`timescale 1ns/1ps
module OTTER_MCU
  import otter_io_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        INTR,
  input  logic [31:0] IOBUS_IN,
  output logic [31:0] IOBUS_OUT,
  output logic [31:0] IOBUS_ADDR,
  output logic        IOBUS_WR
);

  logic [31:0] data_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= 32'h0;
    end else begin
      data_q <= IOBUS_IN;
    end
  end

  assign IOBUS_ADDR = INTR ? LEDS_AD : SWITCHES_AD;
  assign IOBUS_OUT  = data_q;
  assign IOBUS_WR   = INTR;

endmodule

// File: rtl/sev_seg_disp.sv
// Four-digit multiplexed hex display: free-running scan counter, digit mux and
// registered active-low anode/segment outputs.
`timescale 1ns/1ps
module sev_seg_disp
  import otter_io_pkg::*;
#(
  parameter int REFRESH_BITS = 17
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] val_i,
  output logic [3:0]  an_o,
  output logic [7:0]  segs_o
);

  logic [REFRESH_BITS-1:0] cnt_q;
  logic [1:0]              sel_s;
  logic [3:0]              an_d;
  logic [3:0]              nib_s;
  logic [3:0]              an_q;
  logic [7:0]              segs_q;

  assign sel_s = cnt_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    an_d  = AN_OFF;
    nib_s = 4'h0;
    case (sel_s)
      2'd0: begin an_d = 4'b1110; nib_s = val_i[3:0];   end
      2'd1: begin an_d = 4'b1101; nib_s = val_i[7:4];   end
      2'd2: begin an_d = 4'b1011; nib_s = val_i[11:8];  end
      2'd3: begin an_d = 4'b0111; nib_s = val_i[15:12]; end
      default: begin an_d = AN_OFF; nib_s = 4'h0; end
    endcase
  end

  // Outputs lag the counter by one clk so they stay glitch-free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      an_q   <= AN_OFF;
      segs_q <= SEGS_BLANK;
    end else begin
      cnt_q  <= cnt_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      an_q   <= an_d;
      segs_q <= hex_to_segs(nib_s);
    end
  end

  assign an_o   = an_q;
  assign segs_o = segs_q;

endmodule

// File: rtl/otter_io_wrapper.sv
// Board wrapper for the OTTER MCU: clock divider, button reset/interrupt
// handling and the memory-mapped switch/button/LED/display I/O.
`timescale 1ns/1ps
module otter_io_wrapper
  import otter_io_pkg::*;
(
  input  logic        clk,
  input  logic [4:0]  buttons,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic [7:0]  segs,
  output logic [3:0]  an
);

  logic        rst_s;
  logic        sclk_q;
  logic [31:0] iobus_in_s;
  logic [31:0] iobus_out_s;
  logic [31:0] iobus_addr_s;
  logic        iobus_wr_s;
  logic [15:0] leds_q;
  logic [15:0] sseg_val_q;
  logic        intr_sync1_q;
  logic        intr_sync2_q;
  logic        intr_prev_q;
  logic        intr_d;
  logic        intr_q;
  logic        out_hi_unused_s;

  assign rst_s           = buttons[3];
  assign out_hi_unused_s = |iobus_out_s[31:16];

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      sclk_q <= 1'b0;
    end else begin
      sclk_q <= ~sclk_q;
    end
  end

  OTTER_MCU u_mcu (
    .CLK        (sclk_q),
    .RST        (rst_s),
    .INTR       (intr_q),
    .IOBUS_IN   (iobus_in_s),
    .IOBUS_OUT  (iobus_out_s),
    .IOBUS_ADDR (iobus_addr_s),
    .IOBUS_WR   (iobus_wr_s)
  );

  always_comb begin
    iobus_in_s = 32'h0;
    case (iobus_addr_s)
      SWITCHES_AD: iobus_in_s = {16'h0, switches};
      BUTTONS_AD:  iobus_in_s = {27'h0, buttons};
      default:     iobus_in_s = 32'h0;
    endcase
  end

  always_ff @(posedge sclk_q or posedge rst_s) begin
    if (rst_s) begin
      leds_q     <= 16'h0;
      sseg_val_q <= 16'h0;
    end else if (iobus_wr_s) begin
      case (iobus_addr_s)
        LEDS_AD: leds_q     <= iobus_out_s[15:0];
        SSEG_AD: sseg_val_q <= iobus_out_s[15:0];
        default: ;
      endcase
    end
  end

  // Two-flop synchronizer, then a one-shot on the synchronized rising edge.
  assign intr_d = intr_sync2_q & ~intr_prev_q;

  always_ff @(posedge sclk_q or posedge rst_s) begin
    if (rst_s) begin
      intr_sync1_q <= 1'b0;
      intr_sync2_q <= 1'b0;
      intr_prev_q  <= 1'b0;
      intr_q       <= 1'b0;
    end else begin
      intr_sync1_q <= buttons[4];
      intr_sync2_q <= intr_sync1_q;
      intr_prev_q  <= intr_sync2_q;
      intr_q       <= intr_d;
    end
  end

  sev_seg_disp #(.REFRESH_BITS(17)) u_disp (
    .clk_i  (clk),
    .rst_i  (rst_s),
    .val_i  (sseg_val_q),
    .an_o   (an),
    .segs_o (segs)
  );

  assign leds = leds_q;

endmodule

// File: tb/tb_otter_io_wrapper.sv
// Directed bench for otter_io_wrapper; the MCU bus is overridden from here so
// the I/O decode can be exercised without running firmware.
`timescale 1ns/1ps
module tb_otter_io_wrapper;
  import otter_io_pkg::*;

  logic        clk = 1'b0;
  logic [4:0]  buttons;
  logic [15:0] switches;
  logic [15:0] leds;
  logic [7:0]  segs;
  logic [3:0]  an;

  logic        r4_rst;
  logic [3:0]  r4_an;
  logic [7:0]  r4_segs;

  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_wr;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic [31:0] exp_in;
    logic [15:0] exp_leds;
    logic [15:0] exp_sseg;
  } vec_t;

  vec_t       vecs[11];
  logic [3:0] exp_an4[4];
  logic [7:0] exp_seg4[4];

  longint t1, t2;
  int     pulses, highs, d;
  logic   prev, found;

  otter_io_wrapper dut (
    .clk      (clk),
    .buttons  (buttons),
    .switches (switches),
    .leds     (leds),
    .segs     (segs),
    .an       (an)
  );

  sev_seg_disp #(.REFRESH_BITS(4)) u_disp4 (
    .clk_i  (clk),
    .rst_i  (r4_rst),
    .val_i  (16'h1A2F),
    .an_o   (r4_an),
    .segs_o (r4_segs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    vecs[0]  = '{SWITCHES_AD,   32'h0000_0000, 1'b0, 16'h1234, 5'b00000, 32'h0000_1234, 16'h0000, 16'h0000};
    vecs[1]  = '{BUTTONS_AD,    32'h0000_0000, 1'b0, 16'h1234, 5'b00101, 32'h0000_0005, 16'h0000, 16'h0000};
    vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 16'h1234, 5'b00101, 32'h0000_0000, 16'h0000, 16'h0000};
    vecs[3]  = '{LEDS_AD,       32'h0000_A5A5, 1'b1, 16'h1234, 5'b00000, 32'h0000_0000, 16'hA5A5, 16'h0000};
    vecs[4]  = '{32'h1104_0000, 32'h0000_FFFF, 1'b1, 16'h1234, 5'b00000, 32'h0000_0000, 16'hA5A5, 16'h0000};
    vecs[5]  = '{SSEG_AD,       32'h0000_1A2F, 1'b1, 16'h1234, 5'b00000, 32'h0000_0000, 16'hA5A5, 16'h1A2F};
    vecs[6]  = '{LEDS_AD,       32'h1234_5678, 1'b0, 16'h1234, 5'b00000, 32'h0000_0000, 16'hA5A5, 16'h1A2F};
    vecs[7]  = '{SWITCHES_AD,   32'hFFFF_3C3C, 1'b1, 16'hFFFF, 5'b00000, 32'h0000_FFFF, 16'hA5A5, 16'h1A2F};
    vecs[8]  = '{BUTTONS_AD,    32'h0000_0000, 1'b0, 16'hFFFF, 5'b10110, 32'h0000_0016, 16'hA5A5, 16'h1A2F};
    vecs[9]  = '{LEDS_AD,       32'hFFFF_3C3C, 1'b1, 16'hFFFF, 5'b00000, 32'h0000_0000, 16'h3C3C, 16'h1A2F};
    vecs[10] = '{LEDS_AD,       32'h0000_A5A5, 1'b1, 16'hFFFF, 5'b00000, 32'h0000_0000, 16'hA5A5, 16'h1A2F};
    exp_an4  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg4 = '{8'h8E, 8'hA4, 8'h88, 8'hF9};

    buttons  = 5'b01000;
    switches = 16'h0000;
    r4_rst   = 1'b1;
    bus_addr = 32'h0;
    bus_data = 32'h0;
    bus_wr   = 1'b0;
    force dut.iobus_addr_s = bus_addr;
    force dut.iobus_out_s  = bus_data;
    force dut.iobus_wr_s   = bus_wr;

    // Reset held for 80 ns
    #79;
    check("rst_leds", {16'h0, leds}, 32'h0);
    check("rst_an", {28'h0, an}, 32'hF);
    check("rst_segs", {24'h0, segs}, 32'hFF);
    check("rst_intr", {31'h0, dut.intr_q}, 32'h0);
    check("rst_sclk", {31'h0, dut.sclk_q}, 32'h0);
    #1;
    buttons = 5'b00000;
    @(posedge dut.sclk_q); t1 = $time;
    @(posedge dut.sclk_q); t2 = $time;
    check("sclk_first_edge", 32'(t1), 32'd85);
    check("sclk_period", 32'(t2 - t1), 32'd20);

    // Bus decode table
    for (int i = 0; i < 11; i++) begin
      @(posedge dut.sclk_q); #1;
      bus_addr = vecs[i].addr;
      bus_data = vecs[i].wdata;
      bus_wr   = vecs[i].wr;
      switches = vecs[i].sw;
      buttons  = vecs[i].btn;
      #2;
      check($sformatf("vec%0d_iobus_in", i), dut.iobus_in_s, vecs[i].exp_in);
      @(posedge dut.sclk_q); #1;
      bus_wr = 1'b0;
      check($sformatf("vec%0d_leds", i), {16'h0, leds}, {16'h0, vecs[i].exp_leds});
      check($sformatf("vec%0d_sseg", i), {16'h0, dut.sseg_val_q}, {16'h0, vecs[i].exp_sseg});
    end
    buttons  = 5'b00000;
    bus_addr = 32'h0;
    repeat (10) @(posedge dut.sclk_q);

    // Top-level display: digit 0 now, digit 1 once the 17-bit counter rolls its top bits
    @(negedge clk);
    check("top_disp_an0", {28'h0, an}, 32'hE);
    check("top_disp_segs0", {24'h0, segs}, 32'h8E);
    found = 1'b0;
    for (int c = 0; c < 40000 && !found; c++) begin
      @(negedge clk);
      if (an == 4'b1101) found = 1'b1;
    end
    check("top_disp_digit1_reached", {31'h0, found}, 32'h1);
    check("top_disp_segs1", {24'h0, segs}, 32'hA4);

    // Scan order with a 4-bit refresh counter
    check("d4_blank", {20'h0, r4_an, r4_segs}, 32'hFFF);
    @(negedge clk);
    r4_rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      d = ((k - 1) / 4) % 4;
      check($sformatf("d4_cyc%0d", k), {20'h0, r4_an, r4_segs}, {20'h0, exp_an4[d], exp_seg4[d]});
    end

    // Interrupt latency and no repeat while held
    @(posedge dut.sclk_q); #1;
    buttons = 5'b10000;
    for (int e = 1; e <= 4; e++) begin
      @(posedge dut.sclk_q); #1;
      check($sformatf("intr_lat_edge%0d", e), {31'h0, dut.intr_q}, {31'h0, (e == 3)});
    end
    highs = 0;
    repeat (8) begin
      @(posedge dut.sclk_q); #1;
      if (dut.intr_q) highs++;
    end
    check("intr_hold_no_repeat", 32'(highs), 32'd0);
    buttons = 5'b00000;
    repeat (6) @(posedge dut.sclk_q);

    // Two 160 ns presses separated by 750 ns
    pulses = 0;
    highs  = 0;
    prev   = 1'b0;
    fork
      begin
        buttons = 5'b10000; #160;
        buttons = 5'b00000; #750;
        buttons = 5'b10000; #160;
        buttons = 5'b00000;
      end
      begin
        repeat (130) begin
          @(negedge clk);
          if (dut.intr_q && !prev) pulses++;
          if (dut.intr_q) highs++;
          prev = dut.intr_q;
        end
      end
    join
    check("intr_pulse_count", 32'(pulses), 32'd2);
    check("intr_high_half_sclk", 32'(highs), 32'd4);

    // Reset while an interrupt pulse is live
    @(posedge dut.sclk_q); #1;
    buttons = 5'b10000;
    repeat (3) @(posedge dut.sclk_q);
    #1;
    check("pre_rst_intr", {31'h0, dut.intr_q}, 32'h1);
    check("pre_rst_leds", {16'h0, leds}, 32'hA5A5);
    #2;
    buttons = 5'b11000;
    #1;
    check("midrst_intr", {31'h0, dut.intr_q}, 32'h0);
    check("midrst_leds", {16'h0, leds}, 32'h0);
    check("midrst_sseg", {16'h0, dut.sseg_val_q}, 32'h0);
    check("midrst_an", {28'h0, an}, 32'hF);
    check("midrst_segs", {24'h0, segs}, 32'hFF);
    #20;
    buttons = 5'b00000;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/otter_io_wrapper.md
# otter_io_wrapper

Top-level board wrapper for the Exp 7 OTTER RISC-V MCU. It divides the board clock, maps buttons to MCU reset and interrupt, and decodes the MCU I/O bus onto switches, buttons, LEDs and a 4-digit seven-segment display. The MCU core (`OTTER_MCU`) is an existing, separately verified block instantiated inside this one.

## Interface
- No parameters at the top level. Sub-module `sev_seg_disp` takes `REFRESH_BITS`, default 17: width of the digit-scan counter.
- One clock; reset is asynchronous and active-high. Clock port is `clk`. Reset is `buttons[3]`; the codebase has no separate reset port.
- `clk` input 1: 100 MHz board clock.
- `buttons` input 5:
  - `buttons[3]` is reset.
  - `buttons[4]` is the interrupt request.
  - All five bits are readable by the MCU.
- `switches` input 16: slide switches, readable by the MCU.
- `leds` output 16: LED register.
- `segs` output 8: active-low. `segs[7]` = DP (held at 1); `segs[6:0]` = g,f,e,d,c,b,a.
- `an` output 4: active-low digit enables. `an[0]` = rightmost digit.

## Operation
- **Clock divider:** `sclk` toggles on every `clk` rising edge, giving 50 MHz. The MCU and all I/O registers run on `sclk`.
- **MCU port connections:**
  - `RST` = `buttons[3]`.
  - `INTR` = interrupt pulse.
  - `IOBUS_IN`, `IOBUS_OUT`, `IOBUS_ADDR`, `IOBUS_WR` are 32/32/32/1 bits wide.
- **Input mux (combinational, from `IOBUS_ADDR`):**
  - `0x11000000` → `{16'b0, switches}`.
  - `0x11008000` → `{27'b0, buttons}`.
  - Any other address → 0.
- **Output registers:** written on `sclk` rising edge when `IOBUS_WR` = 1.
  - `0x11080000` → `leds <= IOBUS_OUT[15:0]`.
  - `0x110C0000` → `sseg_val <= IOBUS_OUT[15:0]`.
  - A write to any other address changes nothing.
- **Interrupt path:**
  - `buttons[4]` passes through a 2-flop synchronizer on `sclk`, then a rising-edge detector.
  - `INTR` is high for exactly one `sclk` period per press.
  - Holding the button produces no repeat; release followed by a new press gives a new pulse.
- **Display (`sev_seg_disp`):**
  - A free-running `REFRESH_BITS` counter on `clk`. Its top 2 bits select the digit: 0 → `an` = 1110 showing nibble [3:0]; 1 → 1101 [7:4]; 2 → 1011 [11:8]; 3 → 0111 [15:12].
  - Hex decode, active-low (`segs` values): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- **Reset (`buttons[3]` high, asynchronous):**
  - `sclk` = 0.
  - `leds` = 0, `sseg_val` = 0.
  - Refresh counter = 0; `an` = 4'hF and `segs` = 8'hFF (blank).
  - Synchronizer and edge detector cleared; `INTR` = 0.
  - MCU held in reset.

## Timing
- `sclk` period is 2 `clk` cycles. The first `sclk` rising edge is on the 1st `clk` edge after reset deasserts.
- `leds` and `sseg_val` update on the `sclk` edge that samples the write; they are visible to outputs immediately after that edge.
- `INTR` rises 3 `sclk` edges after `buttons[4]` rises (2 synchronizer flops plus the edge register) and is high for 1 `sclk` period.
- A press shorter than 1 `sclk` period may be missed. A 160 ns press must always produce exactly one pulse.
- Display scan begins on the first `clk` after reset release; each digit is shown for 2^(`REFRESH_BITS`-2) `clk` cycles.
- Reset asserted mid-operation clears the registers immediately, regardless of a pending write or interrupt.

## Structure
- Package `otter_io_pkg`:
  - Address constants `SWITCHES_AD`, `BUTTONS_AD`, `LEDS_AD`, `SSEG_AD`.
  - Seven-segment hex decode function.
- Sub-module `sev_seg_disp`, containing the scan counter, digit mux and decoder.
- `OTTER_MCU` is instantiated as is. A stub MCU driving the bus directly is acceptable for unit verification.

## Test plan
- **Reset:** `buttons` = 01000 for 80 ns → `leds` = 0, `an` = F, `segs` = FF, `INTR` = 0. After release, `sclk` period = 20 ns.
- **LED write:** `IOBUS_ADDR` = 0x11080000, `IOBUS_OUT` = 0x0000A5A5, `IOBUS_WR` = 1 for one `sclk` edge → `leds` = A5A5. A write to 0x11040000 leaves `leds` unchanged.
- **Input read:**
  - `switches` = 0x1234, addr 0x11000000 → `IOBUS_IN` = 0x00001234.
  - addr 0x11008000 with `buttons` = 00101 → 0x00000005.
  - addr 0x0 → 0.
- **Interrupt:** `buttons[4]` high for 160 ns, low for 750 ns, then high for 160 ns again → exactly two `INTR` pulses, each 1 `sclk` period wide.
- **Display:** `sseg_val` = 0x1A2F, `REFRESH_BITS` = 4 → `an`/`segs` sequence 1110/8E, 1101/A4, 1011/88, 0111/F9, repeating.
- **Reset mid-operation:** assert `buttons[3]` while `INTR` is high and `leds` = A5A5 → `INTR`, `leds` and display return to reset values within the same `clk` cycle.
